fb_write_arbiter: RTL and testbench

FB_WRITE_ARBITER -- requirements
Module: fb_write_arbiter

---
 rtl/fb_pkg.sv | 17 +
 rtl/fb_write_arbiter_if.sv | 41 ++++
 rtl/fb_clear_engine.sv | 49 ++++
 rtl/fb_write_arbiter.sv | 156 +++++++++++++++
 tb/tb_fb_write_arbiter.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/fb_pkg.sv
// Shared constants and FSM encoding for the frame-buffer write arbiter.
package fb_pkg;

  localparam int FB_ADDR_W = 20;
  localparam int FB_DATA_W = 16;

  // Game FSM encoding: port 0 (trail writer) only writes while playing.
  localparam logic [2:0] PLAYING = 3'b010;

  // Arbiter FSM state, 2-bit encoding.
  typedef logic [1:0] fsm_state_t;
  localparam fsm_state_t ST_IDLE  = 2'd0;
  localparam fsm_state_t ST_OWN0  = 2'd1;
  localparam fsm_state_t ST_OWN1  = 2'd2;
  localparam fsm_state_t ST_CLEAR = 2'd3;

endpackage

// File: rtl/fb_write_arbiter_if.sv
// Write-request bundle between the two pixel writers and the arbiter,
// plus the registered frame-buffer write port.
//
// Handshake: a writer holds req high with addr/data stable; a beat is
// accepted in every cycle where req && gnt, and the writer may then present
// its next beat. gnt never asserts without req. Accepted beats appear on
// fb_addr/fb_data with fb_we=1 exactly one cycle later.
interface fb_write_arbiter_if;
  import fb_pkg::*;

  logic                 p0_req;
  logic [FB_ADDR_W-1:0] p0_addr;
  logic [FB_DATA_W-1:0] p0_data;
  logic                 p0_gnt;

  logic                 p1_req;
  logic [FB_ADDR_W-1:0] p1_addr;
  logic [FB_DATA_W-1:0] p1_data;
  logic                 p1_gnt;

  logic [FB_ADDR_W-1:0] fb_addr;
  logic [FB_DATA_W-1:0] fb_data;
  logic                 fb_we;

  // Writers and the frame-buffer observer.
  modport master (
    output p0_req, p0_addr, p0_data,
    output p1_req, p1_addr, p1_data,
    input  p0_gnt, p1_gnt,
    input  fb_addr, fb_data, fb_we
  );

  // The arbiter.
  modport slave (
    input  p0_req, p0_addr, p0_data,
    input  p1_req, p1_addr, p1_data,
    output p0_gnt, p1_gnt,
    output fb_addr, fb_data, fb_we
  );

endinterface

// File: rtl/fb_clear_engine.sv
// Clear sweep counter: walks CLEAR_BASE .. CLEAR_BASE+CLEAR_WORDS-1, one word
// per advance, and flags the final word.
module fb_clear_engine
  import fb_pkg::*;
#(
  parameter logic [FB_ADDR_W-1:0] CLEAR_BASE  = 20'd0,
  parameter logic [FB_ADDR_W-1:0] CLEAR_WORDS = 20'd76800
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 advance,
  output logic                 busy,
  output logic                 done,
  output logic                 last,
  output logic [FB_ADDR_W-1:0] addr
);

  localparam logic [FB_ADDR_W-1:0] LAST_N = CLEAR_WORDS - FB_ADDR_W'(1);

  logic [FB_ADDR_W-1:0] count;

  assign addr = CLEAR_BASE + count;
  assign last = (count == LAST_N);

  // Sweep counter; a start while busy is ignored so the sweep never restarts.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        count <= '0;
        busy  <= 1'b1;
      end else if (advance && busy) begin
        if (last) begin
          count <= '0;
          busy  <= 1'b0;
          done  <= 1'b1;
        end else begin
          count <= count + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fb_write_arbiter.sv
// Frame-buffer write arbiter: round-robin between the trail writer (port 0)
// and the overlay writer (port 1) with bounded bursts, plus a clear sweep
// that takes absolute priority over both ports.
module fb_write_arbiter
  import fb_pkg::*;
#(
  parameter logic [FB_ADDR_W-1:0] CLEAR_BASE  = 20'd0,
  parameter logic [FB_ADDR_W-1:0] CLEAR_WORDS = 20'd76800,
  parameter int                   MAX_BURST   = 16
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [2:0]          Game_State,
  input  logic                clear_start,
  output logic                clear_busy,
  output logic                clear_done,
  output fsm_state_t          fsm_state,
  fb_write_arbiter_if.slave   bus
);

  localparam int SWEEP_END = int'(CLEAR_BASE) + int'(CLEAR_WORDS) - 1;

  // The sweep must cover at least one word and stay inside the address space.
  if (CLEAR_WORDS == '0 || SWEEP_END > 32'h000F_FFFF) begin : g_bad_clear_params
    $error("fb_write_arbiter: clear sweep range invalid");
  end

  localparam int                CNT_W     = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0]  BURST_MAX = CNT_W'(MAX_BURST);

  fsm_state_t           state;
  logic                 last_owner;   // 1 = port 1 owned the bus last
  logic [CNT_W-1:0]     burst_cnt;
  logic                 elig0, elig1;
  logic                 gnt0, gnt1;
  logic                 eng_busy, eng_done, eng_last;
  logic [FB_ADDR_W-1:0] eng_addr;

  assign elig0 = bus.p0_req && (Game_State == PLAYING);
  assign elig1 = bus.p1_req;

  // Grants: a pending clear or reset suppresses every port beat.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!Reset && !clear_start) begin
      case (state)
        ST_IDLE: begin
          if (elig0 && elig1) begin
            gnt0 = last_owner;
            gnt1 = !last_owner;
          end else begin
            gnt0 = elig0;
            gnt1 = elig1;
          end
        end
        ST_OWN0: gnt0 = elig0 && (burst_cnt < BURST_MAX);
        ST_OWN1: gnt1 = elig1 && (burst_cnt < BURST_MAX);
        default: ;
      endcase
    end
  end

  assign bus.p0_gnt = gnt0;
  assign bus.p1_gnt = gnt1;
  assign fsm_state  = state;
  assign clear_busy = eng_busy;
  assign clear_done = eng_done;

  // Ownership FSM with burst counting; a full burst only yields when the
  // other port is waiting, otherwise it re-arms in place after a gap cycle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= ST_IDLE;
      last_owner <= 1'b1;
      burst_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (clear_start) begin
            state <= ST_CLEAR;
          end else if (gnt0) begin
            state     <= ST_OWN0;
            burst_cnt <= CNT_W'(1);
          end else if (gnt1) begin
            state     <= ST_OWN1;
            burst_cnt <= CNT_W'(1);
          end
        end
        ST_OWN0: begin
          if (clear_start || !elig0 || (burst_cnt == BURST_MAX && elig1)) begin
            state      <= clear_start ? ST_CLEAR : ST_IDLE;
            last_owner <= 1'b0;
            burst_cnt  <= '0;
          end else if (burst_cnt == BURST_MAX) begin
            burst_cnt <= '0;
          end else begin
            burst_cnt <= burst_cnt + 1'b1;
          end
        end
        ST_OWN1: begin
          if (clear_start || !elig1 || (burst_cnt == BURST_MAX && elig0)) begin
            state      <= clear_start ? ST_CLEAR : ST_IDLE;
            last_owner <= 1'b1;
            burst_cnt  <= '0;
          end else if (burst_cnt == BURST_MAX) begin
            burst_cnt <= '0;
          end else begin
            burst_cnt <= burst_cnt + 1'b1;
          end
        end
        default: begin
          if (eng_last) state <= ST_IDLE;
        end
      endcase
    end
  end

  fb_clear_engine #(
    .CLEAR_BASE  (CLEAR_BASE),
    .CLEAR_WORDS (CLEAR_WORDS)
  ) u_clear (
    .clk     (Clk),
    .rst     (Reset),
    .start   (clear_start && (state != ST_CLEAR)),
    .advance (state == ST_CLEAR),
    .busy    (eng_busy),
    .done    (eng_done),
    .last    (eng_last),
    .addr    (eng_addr)
  );

  // Registered frame-buffer write port: clear beat, else the granted port.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      bus.fb_we   <= 1'b0;
      bus.fb_addr <= '0;
      bus.fb_data <= '0;
    end else if (state == ST_CLEAR) begin
      bus.fb_we   <= 1'b1;
      bus.fb_addr <= eng_addr;
      bus.fb_data <= '0;
    end else if (gnt0) begin
      bus.fb_we   <= 1'b1;
      bus.fb_addr <= bus.p0_addr;
      bus.fb_data <= bus.p0_data;
    end else if (gnt1) begin
      bus.fb_we   <= 1'b1;
      bus.fb_addr <= bus.p1_addr;
      bus.fb_data <= bus.p1_data;
    end else begin
      bus.fb_we <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter with a small clear sweep (8 words @ 0x40).
module tb_fb_write_arbiter;
  import fb_pkg::*;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [2:0] Game_State;
  logic       clear_start;
  logic       clear_busy;
  logic       clear_done;
  fsm_state_t fsm_state;

  fb_write_arbiter_if bus();

  fb_write_arbiter #(
    .CLEAR_BASE  (20'h00040),
    .CLEAR_WORDS (20'd8),
    .MAX_BURST   (16)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Game_State  (Game_State),
    .clear_start (clear_start),
    .clear_busy  (clear_busy),
    .clear_done  (clear_done),
    .fsm_state   (fsm_state),
    .bus         (bus)
  );

  // 50 MHz clock
  always #10 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // Expected frame-buffer port per cycle: {we, addr, data}
  logic [36:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive_idle();
    bus.p0_req  = 1'b0;
    bus.p0_addr = '0;
    bus.p0_data = '0;
    bus.p1_req  = 1'b0;
    bus.p1_addr = '0;
    bus.p1_data = '0;
    clear_start = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    Reset = 1'b1;
    drive_idle();
    Game_State = 3'b000;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    check({tag, " rst_fb_we"},   bus.fb_we, 0);
    check({tag, " rst_fb_addr"}, bus.fb_addr, 0);
    check({tag, " rst_fb_data"}, bus.fb_data, 0);
    check({tag, " rst_p0_gnt"},  bus.p0_gnt, 0);
    check({tag, " rst_p1_gnt"},  bus.p1_gnt, 0);
    check({tag, " rst_busy"},    clear_busy, 0);
    check({tag, " rst_done"},    clear_done, 0);
    check({tag, " rst_state"},   fsm_state, ST_IDLE);
    Reset = 1'b0;
    exp_q.delete();
    exp_q.push_back('0);
    @(posedge Clk);
    #1;
  endtask

  // One clock cycle: inputs are already driven; check grants/status at the
  // negedge, check the registered fb port against the scoreboard, and queue
  // the beat expected to appear next cycle.
  task automatic tick(input string tag, input logic g0, input logic g1,
                      input logic clr, input logic [19:0] caddr,
                      input logic busy, input logic done);
    logic [36:0] e;
    @(negedge Clk);
    check({tag, " p0_gnt"},    bus.p0_gnt, g0);
    check({tag, " p1_gnt"},    bus.p1_gnt, g1);
    check({tag, " one_gnt"},   bus.p0_gnt & bus.p1_gnt, 0);
    check({tag, " busy"},      clear_busy, busy);
    check({tag, " done"},      clear_done, done);
    e = exp_q.pop_front();
    check({tag, " fb_we"}, bus.fb_we, e[36]);
    if (e[36]) begin
      check({tag, " fb_addr"}, bus.fb_addr, e[35:16]);
      check({tag, " fb_data"}, bus.fb_data, e[15:0]);
    end
    if (g0)       exp_q.push_back({1'b1, bus.p0_addr, bus.p0_data});
    else if (g1)  exp_q.push_back({1'b1, bus.p1_addr, bus.p1_data});
    else if (clr) exp_q.push_back({1'b1, caddr, 16'h0000});
    else          exp_q.push_back('0);
    @(posedge Clk);
    #1;
  endtask

  initial begin
    logic [19:0] c0, c1;
    int          pos;
    logic        g0, g1;

    Reset      = 1'b1;
    Game_State = 3'b000;
    drive_idle();

    // Reset state
    do_reset("init");

    // Single port-0 beat while playing
    Game_State  = PLAYING;
    bus.p0_req  = 1'b1;
    bus.p0_addr = 20'h00100;
    bus.p0_data = 16'h000F;
    tick("p0_single", 1, 0, 0, 0, 0, 0);
    drive_idle();
    tick("p0_single_out", 0, 0, 0, 0, 0, 0);
    tick("p0_single_gap", 0, 0, 0, 0, 0, 0);

    // Both ports streaming: 16 p0, gap, 16 p1, gap, repeat
    do_reset("rr");
    Game_State = PLAYING;
    bus.p0_req = 1'b1;
    bus.p1_req = 1'b1;
    c0 = '0;
    c1 = '0;
    for (int i = 0; i < 50; i++) begin
      pos = i % 34;
      g0  = (pos < 16);
      g1  = (pos >= 17) && (pos <= 32);
      bus.p0_addr = 20'h01000 + c0;
      bus.p0_data = 16'hA000 + c0[15:0];
      bus.p1_addr = 20'h02000 + c1;
      bus.p1_data = 16'hB000 + c1[15:0];
      tick($sformatf("rr%0d", i), g0, g1, 0, 0, 0, 0);
      if (g0) c0 = c0 + 1'b1;
      if (g1) c1 = c1 + 1'b1;
    end
    drive_idle();
    tick("rr_tail", 0, 0, 0, 0, 0, 0);

    // Port 1 alone: full burst re-arms after one gap cycle, ownership kept
    do_reset("solo");
    bus.p1_req = 1'b1;
    c1 = '0;
    for (int i = 0; i < 18; i++) begin
      g1 = (i != 16);
      bus.p1_addr = 20'h03000 + c1;
      bus.p1_data = 16'hC000 + c1[15:0];
      tick($sformatf("solo%0d", i), 0, g1, 0, 0, 0, 0);
      if (g1) c1 = c1 + 1'b1;
      if (i == 16) check("solo_keep_own1", fsm_state, ST_OWN1);
    end
    drive_idle();
    tick("solo_tail", 0, 0, 0, 0, 0, 0);

    // Port 0 ineligible outside PLAYING; port 1 granted same cycle
    do_reset("elig");
    Game_State  = 3'b000;
    bus.p0_req  = 1'b1;
    bus.p0_addr = 20'h00200;
    bus.p0_data = 16'h1111;
    bus.p1_req  = 1'b1;
    bus.p1_addr = 20'h00300;
    bus.p1_data = 16'h2222;
    tick("elig_p1", 0, 1, 0, 0, 0, 0);
    bus.p1_req = 1'b0;
    tick("elig_p1_out", 0, 0, 0, 0, 0, 0);
    tick("elig_p0_blocked", 0, 0, 0, 0, 0, 0);
    // Game leaves PLAYING mid-burst: grant drops the same cycle
    Game_State = PLAYING;
    tick("gs_b0", 1, 0, 0, 0, 0, 0);
    tick("gs_b1", 1, 0, 0, 0, 0, 0);
    Game_State = 3'b001;
    tick("gs_drop", 0, 0, 0, 0, 0, 0);
    check("gs_drop_state", fsm_state, ST_IDLE);
    drive_idle();
    tick("gs_tail", 0, 0, 0, 0, 0, 0);

    // Clear during a port-1 burst, with a second start ignored at word 3
    do_reset("clr");
    bus.p1_req  = 1'b1;
    bus.p1_addr = 20'h00500;
    bus.p1_data = 16'h5A5A;
    tick("clr_b0", 0, 1, 0, 0, 0, 0);
    tick("clr_b1", 0, 1, 0, 0, 0, 0);
    clear_start = 1'b1;
    tick("clr_start", 0, 0, 0, 0, 0, 0);
    clear_start = 1'b0;
    check("clr_state", fsm_state, ST_CLEAR);
    for (int n = 0; n < 8; n++) begin
      if (n == 3) clear_start = 1'b1;
      tick($sformatf("clr_w%0d", n), 0, 0, 1, 20'h00040 + 20'(n), 1, 0);
      clear_start = 1'b0;
    end
    check("clr_end_state", fsm_state, ST_IDLE);
    tick("clr_done", 0, 1, 0, 0, 0, 1);
    bus.p1_req = 1'b0;
    tick("clr_after", 0, 0, 0, 0, 0, 0);
    tick("clr_quiet", 0, 0, 0, 0, 0, 0);

    // Reset at sweep word 5 aborts the sweep for good
    clear_start = 1'b1;
    tick("ab_start", 0, 0, 0, 0, 0, 0);
    clear_start = 1'b0;
    for (int n = 0; n < 5; n++) begin
      tick($sformatf("ab_w%0d", n), 0, 0, 1, 20'h00040 + 20'(n), 1, 0);
    end
    Reset = 1'b1;
    tick("ab_rst_w5", 0, 0, 0, 0, 1, 0);
    tick("ab_rst_next", 0, 0, 0, 0, 0, 0);
    Reset = 1'b0;
    tick("ab_rel", 0, 0, 0, 0, 0, 0);
    tick("ab_no_resume", 0, 0, 0, 0, 0, 0);
    check("ab_state", fsm_state, ST_IDLE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
